// File: rtl/int2flt_pkg.sv
// Shared types and constants for the int16 -> half-float sequencer.
// Optional build macro INT2FLT_ROUND_EN (consumed by int2flt_rounder) selects round-to-nearest-even.
package int2flt_pkg;

  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;
  localparam int BIAS   = 15;

  // Exponent of a magnitude whose leading one sits at bit 14 before any shift.
  localparam logic [EXP_W-1:0] EXP_START  = EXP_W'(BIAS + 14);
  localparam logic [15:0]      FLT_ZERO   = 16'h0000;
  localparam logic [15:0]      FLT_MAXNEG = 16'hF800;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ARMED    = 4'd1,
    ST_RD_LO    = 4'd2,
    ST_RD_HI    = 4'd3,
    ST_CLASSIFY = 4'd4,
    ST_NORM     = 4'd5,
    ST_ROUND    = 4'd6,
    ST_WR_LO    = 4'd7,
    ST_WR_HI    = 4'd8,
    ST_DONE     = 4'd9
  } state_e;

  function automatic logic [15:0] pack_flt(input logic             sign,
                                           input logic [EXP_W-1:0]  expo,
                                           input logic [MANT_W-1:0] mant);
    return {sign, expo, mant};
  endfunction

endpackage

// File: rtl/int2flt_rounder.sv
// Combinational rounding of a normalized magnitude into exponent + 10-bit mantissa.
// INT2FLT_ROUND_EN defined: round-to-nearest-even; undefined: truncate.
module int2flt_rounder
  import int2flt_pkg::*;
(
  input  logic [13:0]       mag_i,
  input  logic [EXP_W-1:0]  exp_i,
  output logic [EXP_W-1:0]  exp_o,
  output logic [MANT_W-1:0] mant_o
);

`ifdef INT2FLT_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  logic          guard_s;
  logic          sticky_s;
  logic          inc_s;
  logic [MANT_W:0] sum_s;

  // Guard/sticky rounding; a carry out of the mantissa bumps the exponent.
  always_comb begin
    guard_s  = mag_i[3];
    sticky_s = |mag_i[2:0];
    inc_s    = ROUND_EN & guard_s & (sticky_s | mag_i[4]);
    sum_s    = {1'b0, mag_i[13:4]} + {10'd0, inc_s};
    if (sum_s[MANT_W]) begin
      mant_o = 10'd0;
      exp_o  = exp_i + 5'd1;
    end else begin
      mant_o = sum_s[MANT_W-1:0];
      exp_o  = exp_i;
    end
  end

endmodule

// File: rtl/int2flt_seq.sv
// Multicycle int16 -> half-float converter sharing the data-memory port.
// Build macro INT2FLT_ROUND_EN enables round-to-nearest-even (see int2flt_rounder).
module int2flt_seq
  import int2flt_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int SRC_LO = 0,
  parameter int SRC_HI = 1,
  parameter int DST_LO = 2,
  parameter int DST_HI = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data
);

  state_e             state_q, state_d;
  logic [7:0]         lo_q, lo_d, hi_q, hi_d;
  logic               sign_q, sign_d;
  logic [14:0]        mag_q, mag_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [15:0]        res_q, res_d;
  logic               done_q, done_d, busy_q, busy_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               wr_en_q, wr_en_d;
  logic [7:0]         wr_data_q, wr_data_d;

  logic [15:0]        op_s, neg_s;
  logic [EXP_W-1:0]   rnd_exp_s;
  logic [MANT_W-1:0]  rnd_mant_s;

  assign op_s  = {hi_q, lo_q};
  assign neg_s = 16'd0 - op_s;

  int2flt_rounder u_rounder (
    .mag_i  (mag_q[13:0]),
    .exp_i  (exp_q),
    .exp_o  (rnd_exp_s),
    .mant_o (rnd_mant_s)
  );

  // State and registered-output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Datapath flops: operand bytes, sign, magnitude/exponent shifters, result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_q   <= 8'd0;
      hi_q   <= 8'd0;
      sign_q <= 1'b0;
      mag_q  <= 15'd0;
      exp_q  <= 5'd0;
      res_q  <= 16'd0;
    end else begin
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      sign_q <= sign_d;
      mag_q  <= mag_d;
      exp_q  <= exp_d;
      res_q  <= res_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE, DONE and ARMED.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = start ? ST_ARMED : state_q;
      ST_ARMED:         state_d = start ? ST_ARMED : ST_RD_LO;
      ST_RD_LO:         state_d = ST_RD_HI;
      ST_RD_HI:         state_d = ST_CLASSIFY;
      ST_CLASSIFY:      state_d = (op_s[14:0] == 15'd0) ? ST_WR_LO : ST_NORM;
      ST_NORM:          state_d = mag_q[14] ? ST_ROUND : ST_NORM;
      ST_ROUND:         state_d = ST_WR_LO;
      ST_WR_LO:         state_d = ST_WR_HI;
      ST_WR_HI:         state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Datapath next values for each state.
  always_comb begin
    lo_d   = lo_q;
    hi_d   = hi_q;
    sign_d = sign_q;
    mag_d  = mag_q;
    exp_d  = exp_q;
    res_d  = res_q;
    case (state_q)
      ST_RD_LO: lo_d = mem_rd_data;
      ST_RD_HI: hi_d = mem_rd_data;
      ST_CLASSIFY: begin
        sign_d = op_s[15];
        mag_d  = op_s[15] ? neg_s[14:0] : op_s[14:0];
        exp_d  = EXP_START;
        if (op_s[14:0] == 15'd0) begin
          res_d = op_s[15] ? FLT_MAXNEG : FLT_ZERO;
        end else begin
          res_d = res_q;
        end
      end
      ST_NORM: begin
        if (!mag_q[14]) begin
          mag_d = {mag_q[13:0], 1'b0};
          exp_d = exp_q - 5'd1;
        end else begin
          mag_d = mag_q;
          exp_d = exp_q;
        end
      end
      ST_ROUND: res_d = pack_flt(sign_q, rnd_exp_s, rnd_mant_s);
      default: res_d = res_q;
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    done_d    = done_q;
    busy_d    = busy_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    case (state_d)
      ST_ARMED: done_d = 1'b0;
      ST_RD_LO: begin
        busy_d = 1'b1;
        addr_d = ADDR_W'(SRC_LO);
      end
      ST_RD_HI: addr_d = ADDR_W'(SRC_HI);
      ST_WR_LO: begin
        addr_d    = ADDR_W'(DST_LO);
        wr_en_d   = 1'b1;
        wr_data_d = res_d[7:0];
      end
      ST_WR_HI: begin
        addr_d    = ADDR_W'(DST_HI);
        wr_en_d   = 1'b1;
        wr_data_d = res_d[15:8];
      end
      ST_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: wr_en_d = 1'b0;
    endcase
  end

  assign done        = done_q;
  assign busy        = busy_q;
  assign mem_addr    = addr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_int2flt_seq.sv
// Bench for int2flt_seq: data_mem model, arithmetic reference model, per-cycle timeline checks.
module tb_int2flt_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done, busy, mem_wr_en;
  logic [7:0] mem_addr, mem_rd_data, mem_wr_data;
  logic [7:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  logic        track = 1'b0;
  int          cyc = -1;
  int          exp_lat = 0;
  logic [15:0] exp_res = 16'd0;

`ifdef INT2FLT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  int2flt_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .busy        (busy),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;

  always @(posedge clk) if (track) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc=%0d)", name, act, req, cyc);
    end
  endtask

  // Reference conversion from plain integer arithmetic.
  function automatic logic [15:0] model(input logic [15:0] op, output int lat);
    int v, m, p, sh, q, r, half, e;
    logic s;
    v = int'($signed(op));
    if (v == 0) begin lat = 5; return 16'h0000; end
    if (v == -32768) begin lat = 5; return 16'hF800; end
    s = (v < 0);
    m = s ? -v : v;
    p = 0;
    for (int i = 0; i < 15; i++) if (((m >> i) & 1) != 0) p = i;
    lat = 7 + (14 - p);
    e = p + 15;
    if (p > 10) begin
      sh   = p - 10;
      q    = m >> sh;
      r    = m - (q << sh);
      half = 1 << (sh - 1);
      if (RND && (r > half || (r == half && (q % 2) == 1))) q = q + 1;
      if (q == 2048) begin q = 1024; e = e + 1; end
    end else begin
      q = m << (10 - p);
    end
    return {s, 5'(e), 10'(q)};
  endfunction

  // Per-cycle timeline check against the expected latency and result.
  always @(negedge clk) begin
    if (track && cyc >= 0) begin
      check("busy", 32'(busy), 32'(cyc < exp_lat));
      check("done", 32'(done), 32'(cyc >= exp_lat));
      check("wr_en", 32'(mem_wr_en), 32'((cyc == exp_lat - 2) || (cyc == exp_lat - 1)));
      if (cyc == 0) check("rd_lo_addr", 32'(mem_addr), 32'd0);
      if (cyc == 1) check("rd_hi_addr", 32'(mem_addr), 32'd1);
      if (cyc == exp_lat - 2) begin
        check("wr_lo_addr", 32'(mem_addr), 32'd2);
        check("wr_lo_data", 32'(mem_wr_data), 32'(exp_res[7:0]));
      end
      if (cyc == exp_lat - 1) begin
        check("wr_hi_addr", 32'(mem_addr), 32'd3);
        check("wr_hi_data", 32'(mem_wr_data), 32'(exp_res[15:8]));
      end
    end
  end

  task automatic launch(input logic [15:0] op, input logic [15:0] lit);
    int lat;
    mem[0] = op[7:0];
    mem[1] = op[15:8];
    mem[2] = 8'hAA;
    mem[3] = 8'hAA;
    exp_res = model(op, lat);
    exp_lat = lat;
    check("model_vs_literal", 32'(exp_res), 32'(lit));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("done_clear_on_start", 32'(done), 32'd0);
    @(posedge clk); #1 start = 1'b0;
    cyc   = -1;
    track = 1'b1;
  endtask

  task automatic run(input logic [15:0] op, input logic [15:0] lit, input bit glitch);
    int w;
    launch(op, lit);
    w = 0;
    while (cyc < exp_lat + 2 && w < 80) begin
      @(negedge clk);
      if (glitch && cyc == 5) start = 1'b1;
      if (glitch && cyc == 7) start = 1'b0;
      w++;
    end
    if (w >= 80) begin
      total++; bad++;
      $display("FAIL timeout: cyc=%0d want %0d", cyc, exp_lat + 2);
    end
    track = 1'b0;
    check("mem_result", 32'({mem[3], mem[2]}), 32'(exp_res));
  endtask

  initial begin
    logic [15:0] lit_7fff;
    int w;
    lit_7fff = RND ? 16'h7800 : 16'h77FF;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b0;
    start = 1'b0;
    #12;
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wr_data", 32'(mem_wr_data), 32'd0);
    @(negedge clk); reset = 1'b1;

    run(16'h0001, 16'h3C00, 1'b0);
    run(16'h0000, 16'h0000, 1'b0);
    run(16'h8000, 16'hF800, 1'b0);
    run(16'hFFC0, 16'hD400, 1'b0);
    run(16'h022C, 16'h6058, 1'b0);
    run(16'h7FFF, lit_7fff, 1'b0);
    run(16'hFFFF, 16'hBC00, 1'b0);
    run(16'h0001, 16'h3C00, 1'b1);

    // Abort mid-normalization with reset.
    launch(16'h0001, 16'h3C00);
    w = 0;
    while (cyc < 8 && w < 40) begin @(negedge clk); w++; end
    track = 1'b0;
    reset = 1'b0;
    #2;
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wr_en", 32'(mem_wr_en), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("abort_busy_held", 32'(busy), 32'd0);
    check("abort_no_write", 32'({mem[3], mem[2]}), 32'h0000AAAA);
    reset = 1'b1;
    @(negedge clk);
    check("post_abort_idle", 32'(busy), 32'd0);

    run(16'h0003, 16'h4200, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
